// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
// Shared definitions for the Pmod SPI bus arbiter: FSM state encoding and
// default values for the guard interval and idle SCLK level.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_t;

    localparam int   GUARD_DEFAULT     = 4;
    localparam logic IDLE_SCLK_DEFAULT = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches the request vector upward from
// the pointer, wrapping modulo NREQ, and returns the first set bit.
// Ports:
//   req    in   NREQ  eligible requests
//   ptr    in   PW    index searched first
//   winner out  NREQ  one-hot winner (0 when nothing requested)
//   valid  out  1     a winner exists
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one Pmod SPI bus between NREQ masters with round-robin priority and
// a guard interval between owners. The granted master's SCLK/MOSI/CS pass
// straight through from the registered grant; every other CS is held high.
// Optional feature (macro SPI_ARB_TIMEOUT_EN): watchdog that revokes a grant
// after MAX_HOLD cycles, pulses timeout and locks the master out until it
// drops req.
// Ports:
//   Clock, Reset      clock, async active-low reset
//   req[NREQ]         per-master bus request (level)
//   grant[NREQ]       one-hot registered grant
//   sclk_in/mosi_in/cs_in[NREQ]  per-master SPI signals
//   MISO              shared bus MISO pin
//   miso_out[NREQ]    MISO routed to the granted master only
//   SCLK, MOSI, CS[NREQ]  bus pins
//   busy              state is GRANT or GUARD
//   timeout           one-cycle pulse on watchdog revoke
//
// state    | meaning
// ST_IDLE  | no owner, arbitrating each cycle
// ST_GRANT | grant registered, pass-through active
// ST_GUARD | bus idle for GUARD cycles before next arbitration
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int   NREQ      = 2,
    parameter int   GUARD     = GUARD_DEFAULT,
    parameter logic IDLE_SCLK = IDLE_SCLK_DEFAULT,
    parameter int   MAX_HOLD  = 65535
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    input  logic [NREQ-1:0] sclk_in,
    input  logic [NREQ-1:0] mosi_in,
    input  logic [NREQ-1:0] cs_in,
    input  logic            MISO,
    output logic [NREQ-1:0] miso_out,
    output logic            SCLK,
    output logic            MOSI,
    output logic [NREQ-1:0] CS,
    output logic            busy,
    output logic            timeout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d, ptr_nxt;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] req_elig;
    logic [NREQ-1:0] pick_winner;
    logic            pick_valid;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] lockout_q, lockout_d;
    logic            timeout_q, timeout_d;

    assign req_elig = req & ~lockout_q;
    assign timeout  = timeout_q;
`else
    assign req_elig = req;
    assign timeout  = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req_elig),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Pointer moves to just past the winner so it loses the next tie.
    always_comb begin
        ptr_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_winner[i]) begin
                ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gcnt_d  = gcnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
        // A lockout holds only while the master keeps requesting.
        lockout_d = lockout_q & req;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    ptr_d   = ptr_nxt;
                    state_d = ST_GRANT;
`ifdef SPI_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (~|(req & grant_q)) begin
                    grant_d = '0;
                    gcnt_d  = GW'(GUARD - 1);
                    state_d = ST_GUARD;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    grant_d   = '0;
                    gcnt_d    = GW'(GUARD - 1);
                    state_d   = ST_GUARD;
                    timeout_d = 1'b1;
                    lockout_d = lockout_d | grant_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            ST_GUARD: begin
                if (gcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            gcnt_q  <= '0;
            busy_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            hold_q    <= '0;
            lockout_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gcnt_q  <= gcnt_d;
            busy_q  <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            lockout_q <= lockout_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Pass-through is gated by the registered grant: no owner means idle bus.
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign SCLK     = (|grant_q) ? |(sclk_in & grant_q) : IDLE_SCLK;
    assign MOSI     = |(mosi_in & grant_q);
    assign CS       = cs_in | ~grant_q;
    assign miso_out = grant_q & {NREQ{MISO}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

    localparam int   NREQ      = 2;
    localparam int   GUARD     = 4;
    localparam logic IDLE_SCLK = 1'b0;
    localparam int   MAX_HOLD  = 16;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] sclk_in, mosi_in, cs_in;
    logic            miso;
    logic [NREQ-1:0] miso_out;
    logic            sclk, mosi;
    logic [NREQ-1:0] cs;
    logic            busy, timeout;

    int total = 0;
    int bad   = 0;

    spi_bus_arbiter #(
        .NREQ      (NREQ),
        .GUARD     (GUARD),
        .IDLE_SCLK (IDLE_SCLK),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .Clock    (clk),
        .Reset    (rst_n),
        .req      (req),
        .grant    (grant),
        .sclk_in  (sclk_in),
        .mosi_in  (mosi_in),
        .cs_in    (cs_in),
        .MISO     (miso),
        .miso_out (miso_out),
        .SCLK     (sclk),
        .MOSI     (mosi),
        .CS       (cs),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the bus, how many guard cycles remain, where
    // the next search starts, how long the owner has held, who is locked out.
    int owner;
    int cool;
    int ptr;
    int hold;
    bit lock [NREQ];
    bit tpulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        cool   = 0;
        ptr    = 0;
        hold   = 0;
        tpulse = 0;
        for (int i = 0; i < NREQ; i++) lock[i] = 0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] r;
        int c;
        r = req;
        tpulse = 0;
        if (owner >= 0) begin
            if (!r[owner]) begin
                owner = -1;
                cool  = GUARD;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (hold == MAX_HOLD - 1) begin
                lock[owner] = 1;
                owner  = -1;
                cool   = GUARD;
                tpulse = 1;
            end else begin
                hold = hold + 1;
            end
`endif
        end else if (cool > 0) begin
            cool = cool - 1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                c = (ptr + k) % NREQ;
                if (owner < 0 && r[c] && !lock[c]) begin
                    owner = c;
                    ptr   = (c + 1) % NREQ;
                    hold  = 0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) if (!r[i]) lock[i] = 0;
    endtask

    task automatic check_model();
        logic [NREQ-1:0] e_grant, e_cs, e_miso;
        logic e_sclk, e_mosi;
        e_grant = '0;
        e_miso  = '0;
        e_sclk  = IDLE_SCLK;
        e_mosi  = 1'b0;
        for (int i = 0; i < NREQ; i++) e_cs[i] = 1'b1;
        if (owner >= 0) begin
            e_grant[owner] = 1'b1;
            e_cs[owner]    = cs_in[owner];
            e_miso[owner]  = miso;
            e_sclk         = sclk_in[owner];
            e_mosi         = mosi_in[owner];
        end
        chk("m_grant", 32'(grant), 32'(e_grant));
        chk("m_cs", 32'(cs), 32'(e_cs));
        chk("m_sclk", 32'(sclk), 32'(e_sclk));
        chk("m_mosi", 32'(mosi), 32'(e_mosi));
        chk("m_miso", 32'(miso_out), 32'(e_miso));
        chk("m_busy", 32'(busy), 32'((owner >= 0) || (cool > 0)));
        chk("m_timeout", 32'(timeout), 32'(tpulse));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        sclk_in = '0;
        mosi_in = '0;
        cs_in   = '1;
        miso    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model();
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] exp, input int max_cyc, input string name);
        int n;
        n = 0;
        while (grant !== exp && n < max_cyc) begin
            tick();
            n++;
        end
        chk(name, 32'(grant), 32'(exp));
    endtask

    task automatic acquire(input int g);
        logic [NREQ-1:0] e;
        e = '0;
        e[g] = 1'b1;
        req = e;
        wait_grant(e, 20, "acquire");
    endtask

    typedef struct {
        int              gsel;
        logic [NREQ-1:0] s_sclk, s_mosi, s_cs;
        logic            s_miso;
        logic            e_sclk, e_mosi;
        logic [NREQ-1:0] e_cs, e_miso;
    } vec_t;

    vec_t vecs [7];
    logic [NREQ-1:0] got [4];
    logic [NREQ-1:0] fair_exp [4];

    initial begin
        int n;
        logic seen0;

        vecs[0] = '{1, 2'b01, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10};
        vecs[1] = '{1, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00};
        vecs[2] = '{1, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10};
        vecs[3] = '{1, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 2'b11, 2'b10};
        vecs[4] = '{0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01};
        vecs[5] = '{0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 2'b11, 2'b00};
        vecs[6] = '{0, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01};
        fair_exp[0] = 2'b01;
        fair_exp[1] = 2'b10;
        fair_exp[2] = 2'b01;
        fair_exp[3] = 2'b10;

        // Reset values
        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cs", 32'(cs), 32'h3);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single request: grant next cycle, busy for 20 grant + 4 guard cycles
        req = 2'b01;
        tick();
        chk("single_grant", 32'(grant), 32'h1);
        cs_in = 2'b00;
        #1;
        chk("single_cs", 32'(cs), 32'h2);
        cs_in = 2'b11;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 20) req = 2'b00;
            tick();
        end
        chk("single_busy_len", 32'(n), 32'd24);

        // Contention from reset: master 0 first, 4 guard cycles, then master 1
        do_reset();
        req = 2'b11;
        tick();
        chk("cont_first", 32'(grant), 32'h1);
        repeat (3) tick();
        req = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("cont_gap_grant", 32'(grant), 32'h0);
            chk("cont_gap_cs", 32'(cs), 32'h3);
        end
        tick();
        chk("cont_second", 32'(grant), 32'h2);

        // Fairness: both keep requesting, each releases after 10 cycles
        do_reset();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (grant == '0 && n < 20) begin
                tick();
                n++;
            end
            got[k] = grant;
            repeat (9) tick();
            req = req & ~grant;
            tick();
            req = 2'b11;
        end
        for (int k = 0; k < 4; k++) chk("fair_order", 32'(got[k]), 32'(fair_exp[k]));

        // Pass-through / isolation table
        for (int v = 0; v < 7; v++) begin
            if (grant[vecs[v].gsel] !== 1'b1) acquire(vecs[v].gsel);
            sclk_in = vecs[v].s_sclk;
            mosi_in = vecs[v].s_mosi;
            cs_in   = vecs[v].s_cs;
            miso    = vecs[v].s_miso;
            #1;
            chk("vec_sclk", 32'(sclk), 32'(vecs[v].e_sclk));
            chk("vec_mosi", 32'(mosi), 32'(vecs[v].e_mosi));
            chk("vec_cs", 32'(cs), 32'(vecs[v].e_cs));
            chk("vec_miso", 32'(miso_out), 32'(vecs[v].e_miso));
        end

        // Asynchronous reset mid-transfer
        acquire(1);
        sclk_in = 2'b10;
        cs_in   = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_cs", 32'(cs), 32'h3);
        chk("arst_sclk", 32'(sclk), 32'(IDLE_SCLK));
        chk("arst_busy", 32'(busy), 32'h0);
        do_reset();

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: revoke after MAX_HOLD cycles, lock out until req drops
        req = 2'b01;
        tick();
        n = 0;
        while (grant == 2'b01 && n < 100) begin
            n++;
            tick();
        end
        chk("to_hold_len", 32'(n), 32'(MAX_HOLD));
        chk("to_pulse", 32'(timeout), 32'h1);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'h0);
        seen0 = 1'b0;
        repeat (30) begin
            tick();
            if (grant[0]) seen0 = 1'b1;
        end
        chk("to_locked", 32'(seen0), 32'h0);
        req = 2'b00;
        tick();
        req = 2'b01;
        wait_grant(2'b01, 10, "to_regrant");
        do_reset();
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            sclk_in = NREQ'($urandom);
            mosi_in = NREQ'($urandom);
            cs_in   = NREQ'($urandom);
            miso    = 1'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
